// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl
//
// Performs NBYTES-wide add or subtract with a single 8-bit ripple adder. The
// adder is built from 1-bit full-adder stages and is reused once per cycle,
// least significant byte first. Operands are captured on an input valid/ready
// handshake. The carry runs through a register between byte steps. The result
// is held until an output valid/ready handshake completes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operands and opcode present
//   in_ready   controller can accept operands (IDLE only)
//   a, b       W-bit operands, W = 8*NBYTES
//   sub        0 = A+B, 1 = A-B
//   out_valid  result available (DONE only)
//   out_ready  consumer accepts result
//   result     sum/difference modulo 2^W
//   c_out      carry out of the MSB; for subtract, 1 = no borrow
//   overflow   signed two's-complement overflow
//
// Timing: if the accept happens at edge k, out_valid is high from edge
// k+NBYTES. Operations do not overlap.

module byte_serial_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  c_out,
  output logic                  overflow
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  // A single-byte operand would leave no byte sequencing to do.
  if (NBYTES < 2) begin : gen_param_check
    $error("byte_serial_add_ctrl: NBYTES must be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;       // already inverted for subtract
  logic [W-1:0]    result_q, result_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            c_out_q, c_out_d;
  logic            overflow_q, overflow_d;

  // Byte-wide datapath
  logic [IdxW+2:0] byte_base;
  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      byte_sum;
  logic [8:0]      carry_chain;    // carry_chain[i] is the carry into bit i

  assign byte_base = {idx_q, 3'b000};
  assign a_byte    = a_q[byte_base +: 8];
  assign b_byte    = b_q[byte_base +: 8];

  // Eight chained full-adder stages. The carry into bit 0 is the carry
  // register, so subtract works as A + ~B + 1 with no separate increment.
  always_comb begin
    carry_chain    = '0;
    byte_sum       = '0;
    carry_chain[0] = carry_q;
    for (int i = 0; i < 8; i++) begin
      byte_sum[i]      = a_byte[i] ^ b_byte[i] ^ carry_chain[i];
      carry_chain[i+1] = (a_byte[i] & b_byte[i]) |
                         (carry_chain[i] & (a_byte[i] ^ b_byte[i]));
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub;
          idx_d      = '0;
          // Clear so that stale bytes from the previous result never show.
          result_d   = '0;
          c_out_d    = 1'b0;
          overflow_d = 1'b0;
          state_d    = StRun;
        end
      end

      StRun: begin
        result_d[byte_base +: 8] = byte_sum;
        carry_d                  = carry_chain[8];
        idx_d                    = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          c_out_d    = carry_chain[8];
          // Signed overflow: carry into the sign bit differs from carry out.
          overflow_d = carry_chain[7] ^ carry_chain[8];
          idx_d      = '0;
          state_d    = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;

endmodule
